// File: rtl/dual_rail_pkg.sv
// Shared definitions for the dual-rail elastic pipeline.
//   DUAL_RAIL_STAGE_T(W) : packed stage contents {valid, q[W], qbar[W]}
//   rails_ok(q,qbar,w)   : 1 when the low w bits of q and qbar are exact complements
//   sat_max(w)           : all-ones value of a w-bit saturating counter
//   CNT_W_DEFAULT        : default error counter width
// The stage struct depends on WIDTH, so it is provided as a typedef macro that
// each module expands with its own parameter.
`define DUAL_RAIL_STAGE_T(W) struct packed { logic valid; logic [(W)-1:0] q; logic [(W)-1:0] qbar; }

package dual_rail_pkg;

  // Widest rail the helper functions handle; narrower rails are zero-extended.
  localparam int unsigned MAX_W         = 64;
  localparam int unsigned CNT_W_DEFAULT = 8;

  // Bits above w are masked off, so callers may zero-extend both rails.
  function automatic logic rails_ok(input logic [MAX_W-1:0] q,
                                    input logic [MAX_W-1:0] qbar,
                                    input int unsigned      w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << w) - MAX_W'(1));
    return &((q ^ qbar) | ~mask);
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
    return (w >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction

endpackage

// File: rtl/dual_rail_stage.sv
// One elastic dual-rail register stage.
//   clk, rst      : clock, async active-high reset (valid=0, q=0, qbar=all ones)
//   load          : capture d_q/d_qbar and mark the stage full
//   advance       : the held word leaves this stage this cycle
//   d_q, d_qbar   : incoming rails
//   valid, q, qbar: registered stage contents
//   mismatch      : stage is full and its rails are not complements
// load takes priority over advance: a stage that hands its word on and
// receives a new one in the same cycle stays full. An emptied stage keeps
// its stale rails; only valid drops.
module dual_rail_stage
  import dual_rail_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] d_q,
  input  logic [WIDTH-1:0] d_qbar,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             mismatch
);

  typedef `DUAL_RAIL_STAGE_T(WIDTH) stage_t;

  stage_t st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st.valid <= 1'b0;
      st.q     <= '0;
      st.qbar  <= '1;
    end else if (load) begin
      st.valid <= 1'b1;
      st.q     <= d_q;
      st.qbar  <= d_qbar;
    end else if (advance) begin
      st.valid <= 1'b0;
    end
  end

  assign valid    = st.valid;
  assign q        = st.q;
  assign qbar     = st.qbar;
  assign mismatch = st.valid && !rails_ok(MAX_W'(st.q), MAX_W'(st.qbar), WIDTH);

endmodule

// File: rtl/dual_rail_pipe.sv
// Elastic self-checking pipeline of DEPTH dual-rail stages.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : upstream handshake, in_d is the word
//   out_valid/out_ready : downstream handshake, out_q/out_qbar are stage DEPTH-1 rails
//   inj_en, inj_bit     : on a stage-0 load, qbar[inj_bit] takes in_d[inj_bit]
//                         (no effect when inj_bit >= WIDTH or nothing loads)
//   clr_err             : synchronous clear of err_flag/err_stage/err_count
//   err_flag            : sticky "some full stage had disagreeing rails"
//   err_stage           : lowest mismatching stage, captured on the first error
//   err_count           : saturating count of cycles with any mismatch
// Handshake: a word moves across a boundary on a clock edge where valid and
// ready are both high; valid never depends on ready, ready of stage i depends
// only on registered valid bits and out_ready.
module dual_rail_pipe
  import dual_rail_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  localparam int unsigned IB_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned SW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_qbar,
  input  logic             inj_en,
  input  logic [IB_W-1:0]  inj_bit,
  input  logic             clr_err,
  output logic             err_flag,
  output logic [SW-1:0]    err_stage,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic             ready   [DEPTH+1];
  logic             load    [DEPTH];
  logic             advance [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] mm;
  logic [WIDTH-1:0] q_s      [DEPTH];
  logic [WIDTH-1:0] qbar_s   [DEPTH];
  logic [WIDTH-1:0] d_q_s    [DEPTH];
  logic [WIDTH-1:0] d_qbar_s [DEPTH];
  logic [WIDTH-1:0] inj_mask;
  logic [SW-1:0]    low_stage;
  logic             any_mm;

  // Injection flips the complement bit so qbar[b] equals q[b].
  always_comb begin
    inj_mask = '0;
    if (inj_en && (32'(inj_bit) < WIDTH)) begin
      inj_mask = WIDTH'(1) << inj_bit;
    end
  end

  assign ready[DEPTH] = out_ready;
  assign in_ready     = ready[0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // ready_i = !valid_i || ready_{i+1} unrolled: stage i is blocked only
    // when it and every stage after it are full and the sink stalls.
    assign ready[i]   = out_ready || !(&valid[DEPTH-1:i]);
    assign advance[i] = valid[i] && ready[i+1];

    if (i == 0) begin : g_head
      assign load[i]     = in_valid && ready[i];
      assign d_q_s[i]    = in_d;
      assign d_qbar_s[i] = ~in_d ^ inj_mask;
    end else begin : g_body
      assign load[i]     = valid[i-1] && ready[i];
      assign d_q_s[i]    = q_s[i-1];
      assign d_qbar_s[i] = qbar_s[i-1];
    end

    dual_rail_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (load[i]),
      .advance  (advance[i]),
      .d_q      (d_q_s[i]),
      .d_qbar   (d_qbar_s[i]),
      .valid    (valid[i]),
      .q        (q_s[i]),
      .qbar     (qbar_s[i]),
      .mismatch (mm[i])
    );
  end

  // Scan from the top so the lowest mismatching index wins.
  always_comb begin
    low_stage = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (mm[i]) low_stage = SW'(i);
    end
  end

  assign any_mm = |mm;

  // A live mismatch overrides clr_err: the clear restarts the count at 1
  // and re-captures the stage index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag  <= 1'b0;
      err_stage <= '0;
      err_count <= '0;
    end else if (any_mm) begin
      err_flag <= 1'b1;
      if (clr_err) begin
        err_count <= CNT_W'(1);
      end else if (err_count != CNT_MAX) begin
        err_count <= err_count + 1'b1;
      end
      if (!err_flag || clr_err) begin
        err_stage <= low_stage;
      end
    end else if (clr_err) begin
      err_flag  <= 1'b0;
      err_stage <= '0;
      err_count <= '0;
    end
  end

  assign out_valid = valid[DEPTH-1];
  assign out_q     = q_s[DEPTH-1];
  assign out_qbar  = qbar_s[DEPTH-1];

endmodule

// File: tb/tb_dual_rail_pipe.sv
// Bench for dual_rail_pipe (WIDTH=8, DEPTH=3). A second instance with CNT_W=2
// shares all inputs and covers counter saturation.
module tb_dual_rail_pipe;

  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_q;
  logic [7:0] out_qbar;
  logic       inj_en;
  logic [2:0] inj_bit;
  logic       clr_err;
  logic       err_flag;
  logic [1:0] err_stage;
  logic [7:0] err_count;

  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] out_q2;
  logic [7:0] out_qbar2;
  logic       err_flag2;
  logic [1:0] err_stage2;
  logic [1:0] err_count2;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dual_rail_pipe #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_qbar(out_qbar),
    .inj_en(inj_en), .inj_bit(inj_bit), .clr_err(clr_err),
    .err_flag(err_flag), .err_stage(err_stage), .err_count(err_count)
  );

  dual_rail_pipe #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2), .in_d(in_d),
    .out_valid(out_valid2), .out_ready(out_ready), .out_q(out_q2), .out_qbar(out_qbar2),
    .inj_en(inj_en), .inj_bit(inj_bit), .clr_err(clr_err),
    .err_flag(err_flag2), .err_stage(err_stage2), .err_count(err_count2)
  );

  // ---------------- scoreboard state ----------------
  // entry = {accept cycle[15:0], q[7:0], qbar[7:0]}
  logic [31:0] exp_q[$];
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          n_pop   = 0;
  int          cyc     = 0;
  bit          chk_lat = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives inputs at the falling edge, then settles and records what the
  // next rising edge will transfer in each direction.
  task automatic step(input logic v, input logic [7:0] d, input logic ie,
                      input logic [2:0] ib, input logic ordy, input logic clr,
                      output logic acc);
    logic [7:0]  eqb;
    logic [31:0] e;
    logic [15:0] lat;
    @(negedge clk);
    cyc++;
    in_valid  = v;
    in_d      = d;
    inj_en    = ie;
    inj_bit   = ib;
    out_ready = ordy;
    clr_err   = clr;
    #1;
    acc = v && in_ready;
    if (acc) begin
      eqb = ~d;
      if (ie) eqb[ib] = d[ib];
      exp_q.push_back({16'(cyc), d, eqb});
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        check_eq("out_q", {24'b0, out_q}, {24'b0, e[15:8]});
        check_eq("out_qbar", {24'b0, out_qbar}, {24'b0, e[7:0]});
        if (chk_lat) begin
          lat = 16'(cyc) - e[31:16];
          check_eq("latency", {16'b0, lat}, DEPTH);
        end
      end
    end
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, 8'h00, 1'b0, 3'd0, ordy, 1'b0, a);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] stream_w [3] = '{8'hA5, 8'h3C, 8'hFF};
  logic [7:0] bp_w     [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    logic acc;
    int   idx;
    int   pop0;
    int   acc_n;

    rst = 1'b1; in_valid = 1'b0; in_d = '0; out_ready = 1'b0;
    inj_en = 1'b0; inj_bit = '0; clr_err = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", {31'b0, out_valid}, 0);
    check_eq("rst_out_q", {24'b0, out_q}, 32'h00);
    check_eq("rst_out_qbar", {24'b0, out_qbar}, 32'hFF);
    check_eq("rst_err_flag", {31'b0, err_flag}, 0);
    check_eq("rst_err_stage", {30'b0, err_stage}, 0);
    check_eq("rst_err_count", {24'b0, err_count}, 0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    rst = 1'b0;

    // streaming, no stalls
    chk_lat = 1'b1;
    pop0 = n_pop;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, stream_w[i], 1'b0, 3'd0, 1'b1, 1'b0, acc);
      check_eq("stream_acc", {31'b0, acc}, 1);
    end
    repeat (4) idle(1'b1);
    check_eq("stream_pops", n_pop - pop0, 3);
    check_eq("stream_err_count", {24'b0, err_count}, 0);

    // back-pressure: three words fit, the fourth waits upstream
    chk_lat = 1'b0;
    idx = 0;
    pop0 = n_pop;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, bp_w[idx < 4 ? idx : 0], 1'b0, 3'd0, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check_eq("bp_accepts", idx, 3);
    check_eq("bp_in_ready", {31'b0, in_ready}, 0);
    check_eq("bp_out_valid", {31'b0, out_valid}, 1);
    for (int k = 0; k < 20; k++) begin
      step(idx < 4, bp_w[idx < 4 ? idx : 0], 1'b0, 3'd0, 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    check_eq("bp_all_in", idx, 4);
    check_eq("bp_pops", n_pop - pop0, 4);

    // random traffic
    pop0 = n_pop;
    acc_n = 0;
    for (int k = 0; k < 60; k++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 3'd0,
           ($urandom_range(0, 3) != 0), 1'b0, acc);
      if (acc) acc_n++;
    end
    repeat (8) idle(1'b1);
    check_eq("rand_pops", n_pop - pop0, acc_n);
    check_eq("rand_drain", exp_q.size(), 0);
    check_eq("rand_err_flag", {31'b0, err_flag}, 0);

    // reset with two words in flight
    step(1'b1, 8'hC1, 1'b0, 3'd0, 1'b0, 1'b0, acc);
    step(1'b1, 8'hC2, 1'b0, 3'd0, 1'b0, 1'b0, acc);
    idle(1'b0);
    idle(1'b0);
    check_eq("mid_inflight", {31'b0, out_valid}, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_async_valid", {31'b0, out_valid}, 0);
    @(negedge clk);
    #1;
    check_eq("mid_rst_out_valid", {31'b0, out_valid}, 0);
    check_eq("mid_rst_out_q", {24'b0, out_q}, 32'h00);
    check_eq("mid_rst_out_qbar", {24'b0, out_qbar}, 32'hFF);
    check_eq("mid_rst_err_flag", {31'b0, err_flag}, 0);
    check_eq("mid_rst_err_count", {24'b0, err_count}, 0);
    exp_q.delete();
    rst = 1'b0;

    // injection, no stall: 0x0F with bit 2 corrupted -> qbar 0xF4
    chk_lat = 1'b1;
    step(1'b1, 8'h0F, 1'b1, 3'd2, 1'b1, 1'b0, acc);
    check_eq("inj_acc", {31'b0, acc}, 1);
    idle(1'b1);
    check_eq("inj_flag_early", {31'b0, err_flag}, 0);
    idle(1'b1);
    check_eq("inj_flag", {31'b0, err_flag}, 1);
    check_eq("inj_stage", {30'b0, err_stage}, 0);
    check_eq("inj_count1", {24'b0, err_count}, 1);
    idle(1'b1);
    check_eq("inj_count2", {24'b0, err_count}, 2);
    idle(1'b1);
    check_eq("inj_count3", {24'b0, err_count}, 3);
    idle(1'b1);
    check_eq("inj_count_hold", {24'b0, err_count}, 3);
    check_eq("inj_flag_sticky", {31'b0, err_flag}, 1);
    check_eq("inj_stage_hold", {30'b0, err_stage}, 0);

    // inj_en without a load has no effect
    step(1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, acc);
    idle(1'b1);
    check_eq("clr_flag", {31'b0, err_flag}, 0);
    check_eq("clr_count", {24'b0, err_count}, 0);
    check_eq("clr_stage", {30'b0, err_stage}, 0);
    check_eq("clr_count_sat", {30'b0, err_count2}, 0);
    idle(1'b1);
    check_eq("noload_inj_flag", {31'b0, err_flag}, 0);

    // stalled corrupted word: 0x55, bit 0 -> qbar 0xAB
    chk_lat = 1'b0;
    step(1'b1, 8'h55, 1'b1, 3'd0, 1'b0, 1'b0, acc);
    repeat (3) idle(1'b0);
    check_eq("stall_out_valid", {31'b0, out_valid}, 1);
    check_eq("stall_count2", {24'b0, err_count}, 2);
    check_eq("stall_stage", {30'b0, err_stage}, 0);
    repeat (5) idle(1'b0);
    check_eq("stall_count7", {24'b0, err_count}, 7);
    check_eq("stall_still_held", {31'b0, out_valid}, 1);
    check_eq("sat_count", {30'b0, err_count2}, 3);
    // clear while the mismatch is still present
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, acc);
    idle(1'b1);
    check_eq("clr_live_count", {24'b0, err_count}, 1);
    check_eq("clr_live_flag", {31'b0, err_flag}, 1);
    check_eq("clr_live_stage", {30'b0, err_stage}, 2);
    check_eq("clr_live_sat_count", {30'b0, err_count2}, 1);
    repeat (3) idle(1'b1);

    // ---------------- report ----------------
    check_eq("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
